// File: rtl/gcd_sched_pkg.sv
// Shared types, defaults and the round-robin grant helper for the GCD scheduler.
package gcd_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_W   = 32;
  localparam int DEF_CW  = 32;
  localparam int MAXREQ  = 16;

  // One-hot grant of the first valid lane at or after ptr, wrapping within nreq lanes.
  function automatic logic [MAXREQ-1:0] rr_next_grant(input logic [3:0] ptr,
                                                      input logic [MAXREQ-1:0] valid,
                                                      input int nreq);
    logic [MAXREQ-1:0] g;
    logic found;
    int idx;
    g = '0;
    found = 1'b0;
    for (int i = 0; i < MAXREQ; i++) begin
      if (i < nreq) begin
        idx = (int'(ptr) + i) % nreq;
        if (!found && valid[idx]) begin
          g[idx] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/gcd_sched_engine.sv
// Subtractive GCD datapath: holds u/v, subtracts the smaller from the larger each step.
module gcd_step_engine #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] u_in,
  input  logic [W-1:0] v_in,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         step
);

  logic [W-1:0] u;
  logic [W-1:0] v;

  // Once either operand reaches zero the other one is the gcd, so u+v is the result.
  assign done = (u == '0) || (v == '0);
  assign sum  = u + v;
  assign step = run && !done;

  // Load operands on accept, otherwise perform one subtraction per running cycle.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      u <= '0;
      v <= '0;
    end else if (load) begin
      u <= u_in;
      v <= v_in;
    end else if (step) begin
      if (v <= u) u <= u - v;
      else        v <= v - u;
    end
  end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that time-shares one gcd_step_engine among NREQ requesters.
module gcd_rr_scheduler
  import gcd_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DEF_W,
  parameter int CW   = DEF_CW,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_u,
  input  logic [NREQ*W-1:0] req_v,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic [CW-1:0]     rsp_steps,
  output logic              busy
);

  localparam logic [IW-1:0] LAST_LANE = IW'(NREQ - 1);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] next_ptr;
  logic          accept;
  logic [W-1:0]  sel_u;
  logic [W-1:0]  sel_v;
  logic          eng_done;
  logic          eng_step;
  logic [W-1:0]  eng_sum;

  // Combinational grant, only offered while idle; the accept edge is any granted valid lane.
  always_comb begin
    grant     = NREQ'(rr_next_grant(4'(rr_ptr), 16'(req_valid), NREQ));
    req_ready = (state == S_IDLE) ? grant : '0;
    accept    = |req_ready;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IW'(i);
    end
    next_ptr = (grant_idx == LAST_LANE) ? '0 : grant_idx + IW'(1);
    sel_u    = req_u[grant_idx*W +: W];
    sel_v    = req_v[grant_idx*W +: W];
  end

  assign busy = (state != S_IDLE);

  gcd_step_engine #(.W(W)) u_engine (
    .clk     (clk),
    .reset_l (reset_l),
    .load    (accept),
    .run     (state == S_RUN),
    .u_in    (sel_u),
    .v_in    (sel_v),
    .done    (eng_done),
    .sum     (eng_sum),
    .step    (eng_step)
  );

  // Scheduler FSM: grant and capture, count engine steps, then hold the response until taken.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_steps  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rsp_id    <= grant_idx;
            rsp_steps <= '0;
            rr_ptr    <= next_ptr;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (eng_done) begin
            rsp_result <= eng_sum;
            rsp_valid  <= 1'b1;
            state      <= S_DONE;
          end else if (eng_step && (rsp_steps != '1)) begin
            rsp_steps <= rsp_steps + CW'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Self-checking bench: randomized and directed jobs against a gcd/round-robin model.
module tb_gcd_rr_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam int CW   = 8;
  localparam int SMAX = (1 << CW) - 1;

  logic              clk;
  logic              reset_l;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_u;
  logic [NREQ*W-1:0] req_v;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_result;
  logic [CW-1:0]     rsp_steps;
  logic              busy;

  gcd_rr_scheduler #(.NREQ(NREQ), .W(W), .CW(CW)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .req_valid  (req_valid),
    .req_u      (req_u),
    .req_v      (req_v),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_steps  (rsp_steps),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Per-lane job lists feeding the driver.
  logic [W-1:0] job_u [NREQ][16];
  logic [W-1:0] job_v [NREQ][16];
  int job_n [NREQ];
  int job_i [NREQ];

  // Model state and per-job log written only by the compare process.
  int m_phase = 0;
  int m_ptr   = 0;
  int m_left  = 0;
  int m_id    = 0;
  logic [31:0] m_res   = 0;
  logic [31:0] m_steps = 0;
  bit m_logged = 1'b0;
  int n_acc = 0;
  int n_rsp = 0;
  int log_lane [256];
  int log_acc  [256];
  int log_rise [256];
  logic [31:0] log_rid [256];
  logic [31:0] log_res [256];
  logic [31:0] log_stp [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Euclid by division: gcd plus the number of subtractions the subtractive form needs.
  function automatic void gcd_model(input int unsigned u, input int unsigned v,
                                    output int unsigned res, output int unsigned steps);
    int unsigned a, b, r;
    a = (u > v) ? u : v;
    b = (u > v) ? v : u;
    steps = 0;
    while (b != 0) begin
      steps += a / b;
      r = a % b;
      a = b;
      b = r;
    end
    res = a;
  endfunction

  // Every falling edge: compare DUT against the model, then predict the next rising edge.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    int g, idx;
    bit found;
    int unsigned res, raw;
    if (!reset_l) begin
      m_phase = 0;
      m_ptr   = 0;
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
    end else begin
      exp_ready = '0;
      found = 1'b0;
      g = 0;
      if (m_phase == 0) begin
        for (int i = 0; i < NREQ; i++) begin
          idx = (m_ptr + i) % NREQ;
          if (!found && req_valid[idx]) begin
            found = 1'b1;
            g = idx;
            exp_ready[idx] = 1'b1;
          end
        end
      end
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("busy", 32'(busy), 32'(m_phase != 0));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
        checkOutput("rsp_result", 32'(rsp_result), m_res);
        checkOutput("rsp_steps", 32'(rsp_steps), m_steps);
        if (!m_logged && n_rsp < 256) begin
          log_rise[n_rsp] = cyc;
          log_rid[n_rsp]  = 32'(rsp_id);
          log_res[n_rsp]  = 32'(rsp_result);
          log_stp[n_rsp]  = 32'(rsp_steps);
          n_rsp++;
        end
        m_logged = 1'b1;
      end
      case (m_phase)
        0: if (found) begin
          gcd_model(int'(req_u[g*W +: W]), int'(req_v[g*W +: W]), res, raw);
          m_res   = res;
          m_steps = (raw > SMAX) ? SMAX : raw;
          m_left  = int'(raw);
          m_id    = g;
          m_ptr   = (g + 1) % NREQ;
          m_phase = 1;
          m_logged = 1'b0;
          if (n_acc < 256) begin
            log_lane[n_acc] = g;
            log_acc[n_acc]  = cyc + 1;
            n_acc++;
          end
        end
        1: if (m_left == 0) m_phase = 2; else m_left--;
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  task automatic clearJobs();
    for (int l = 0; l < NREQ; l++) begin
      job_n[l] = 0;
      job_i[l] = 0;
    end
  endtask

  task automatic loadJob(input int lane, input int unsigned u, input int unsigned v);
    job_u[lane][job_n[lane]] = W'(u);
    job_v[lane][job_n[lane]] = W'(v);
    job_n[lane]++;
  endtask

  task automatic doReset();
    @(posedge clk);
    #3;
    reset_l   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_l = 1'b1;
  endtask

  // Drive loaded jobs until all are consumed; mode 0 ready=1, 1 random ready, 2 hold 10 cycles.
  task automatic applyStimulus(input int mode, input bit gaps);
    logic [NREQ-1:0] acc;
    int hold_n;
    bit finished;
    hold_n = 0;
    finished = 1'b0;
    for (int c = 0; c < 30000 && !finished; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int l = 0; l < NREQ; l++) begin
        if (acc[l]) job_i[l]++;
        if (job_i[l] < job_n[l]) begin
          req_u[l*W +: W] = job_u[l][job_i[l]];
          req_v[l*W +: W] = job_v[l][job_i[l]];
          req_valid[l] = !gaps || ($urandom_range(0, 3) != 0);
        end else begin
          req_valid[l] = 1'b0;
        end
      end
      case (mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        default: begin
          if (rsp_valid) hold_n++;
          rsp_ready = (hold_n > 10);
        end
      endcase
      finished = 1'b1;
      for (int l = 0; l < NREQ; l++) if (job_i[l] < job_n[l]) finished = 1'b0;
      if (busy || rsp_valid) finished = 1'b0;
    end
    if (!finished) checkOutput("stimulus_timeout", 32'd1, 32'd0);
    req_valid = '0;
  endtask

  initial begin
    int unsigned r, s;
    int b, t;
    reset_l   = 1'b1;
    req_valid = '0;
    req_u     = '0;
    req_v     = '0;
    rsp_ready = 1'b0;
    clearJobs();
    #1 reset_l = 1'b0;
    #1;
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_rsp_result", 32'(rsp_result), 32'd0);
    checkOutput("rst_rsp_steps", 32'(rsp_steps), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset_l = 1'b1;

    // Pin the model against hand-worked values.
    gcd_model(12, 18, r, s); checkOutput("model_12_18_res", r, 6); checkOutput("model_12_18_stp", s, 3);
    gcd_model(0, 0, r, s);   checkOutput("model_0_0_res", r, 0);   checkOutput("model_0_0_stp", s, 0);
    gcd_model(0, 9, r, s);   checkOutput("model_0_9_res", r, 9);   checkOutput("model_0_9_stp", s, 0);
    gcd_model(7, 7, r, s);   checkOutput("model_7_7_res", r, 7);   checkOutput("model_7_7_stp", s, 1);
    gcd_model(7, 5, r, s);   checkOutput("model_7_5_res", r, 1);   checkOutput("model_7_5_stp", s, 5);

    $display("[TB] test 1: single lane 2 job");
    b = n_rsp;
    clearJobs();
    loadJob(2, 12, 18);
    applyStimulus(0, 1'b0);
    checkOutput("t1_id", log_rid[b], 2);
    checkOutput("t1_result", log_res[b], 6);
    checkOutput("t1_steps", log_stp[b], 3);
    checkOutput("t1_latency", 32'(log_rise[b] - log_acc[b]), 4);

    $display("[TB] test 2: all lanes from pointer 0");
    doReset();
    b = n_rsp;
    clearJobs();
    loadJob(0, 48, 36);
    loadJob(1, 7, 5);
    loadJob(2, 0, 9);
    loadJob(3, 0, 0);
    applyStimulus(0, 1'b0);
    checkOutput("t2_id0", log_rid[b], 0);     checkOutput("t2_res0", log_res[b], 12);
    checkOutput("t2_stp0", log_stp[b], 4);    checkOutput("t2_id1", log_rid[b+1], 1);
    checkOutput("t2_res1", log_res[b+1], 1);  checkOutput("t2_stp1", log_stp[b+1], 5);
    checkOutput("t2_id2", log_rid[b+2], 2);   checkOutput("t2_res2", log_res[b+2], 9);
    checkOutput("t2_stp2", log_stp[b+2], 0);  checkOutput("t2_id3", log_rid[b+3], 3);
    checkOutput("t2_res3", log_res[b+3], 0);  checkOutput("t2_stp3", log_stp[b+3], 0);

    $display("[TB] test 3: lanes 1 and 3 alternate");
    doReset();
    b = n_rsp;
    clearJobs();
    for (int k = 0; k < 4; k++) begin
      loadJob(1, 6 + k, 4);
      loadJob(3, 9, 3 + k);
    end
    applyStimulus(0, 1'b0);
    for (int k = 0; k < 8; k++) checkOutput("t3_order", log_rid[b+k], (k % 2 == 0) ? 1 : 3);

    $display("[TB] test 4: response held 10 cycles");
    clearJobs();
    loadJob(0, 9, 6);
    loadJob(1, 20, 8);
    applyStimulus(2, 1'b0);

    $display("[TB] test 5: reset during a long job");
    clearJobs();
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_u[1*W +: W] = W'(1);
    req_v[1*W +: W] = W'(1000);
    req_valid = 4'b0010;
    t = 0;
    while (t < 50) begin
      @(negedge clk);
      if (req_ready[1]) break;
      t++;
    end
    if (t >= 50) checkOutput("t5_grant_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (20) @(posedge clk);
    #3 reset_l = 1'b0;
    #1;
    checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("t5_rsp_steps", 32'(rsp_steps), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset_l = 1'b1;
    b = n_rsp;
    loadJob(1, 3, 6);
    loadJob(0, 5, 10);
    applyStimulus(0, 1'b0);
    checkOutput("t5_first_id", log_rid[b], 0);
    checkOutput("t5_rsp_count", 32'(n_rsp - b), 2);

    $display("[TB] test 6: step counter saturation");
    b = n_rsp;
    clearJobs();
    loadJob(3, (1 << W) - 1, 1);
    applyStimulus(0, 1'b0);
    checkOutput("t6_result", log_res[b], 1);
    checkOutput("t6_steps", log_stp[b], SMAX);

    $display("[TB] random jobs with gaps and random rsp_ready");
    for (int pass = 0; pass < 2; pass++) begin
      clearJobs();
      for (int l = 0; l < NREQ; l++) begin
        for (int k = 0; k < 6; k++) begin
          r = $urandom_range(0, 255);
          s = ($urandom_range(0, 7) == 0) ? 0 : (($urandom_range(0, 7) == 0) ? r : $urandom_range(0, 255));
          if ($urandom_range(0, 7) == 0) r = 0;
          loadJob(l, r, s);
        end
      end
      applyStimulus(1, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
